instr_encoder: RTL and testbench



---
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-level requests to 32-bit R/I-type words, buffered in a FIFO
// Optional feature: ENC_PARITY_EN adds out_parity, stored as a 33rd FIFO bit.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] count
`ifdef ENC_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef ENC_PARITY_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [31:0]      enc_word;
  logic             enc_legal;
  logic [DW-1:0]    wr_data;
  logic             accept, push, pop;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_op)
      4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      4'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      4'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      4'd3: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      4'd4: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      4'd5: enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000000};
      4'd6: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd7: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd8: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd9: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_PARITY_EN
  assign wr_data = {^enc_word, enc_word};
`else
  assign wr_data = enc_word;
`endif

  // Full/empty come only from the registered count; no same-cycle pass-through.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept && !enc_legal;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign err       = err_q;
  assign count     = count_q;

`ifdef ENC_PARITY_EN
  assign out_parity = out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder against a queue model
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [2:0]  count;
`ifdef ENC_PARITY_EN
  logic        out_parity;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic        err_exp;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
  } req_t;

  req_t held[5];

  instr_encoder #(.DEPTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .count     (count)
`ifdef ENC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

  // Field positions from the architectural layout: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
  function automatic logic [31:0] ref_enc(input req_t r);
    int funct_tab[6]  = '{32, 34, 36, 37, 42, 0};
    int opcode_tab[4] = '{35, 43, 4, 8};
    int w;
    if (r.op <= 4'd5) begin
      w = (r.op == 4'd5) ? 0 : (int'(r.rs) * (1 << 21));
      w += int'(r.rt) * (1 << 16) + int'(r.rd) * (1 << 11);
      if (r.op == 4'd5) w += int'(r.sh) * (1 << 6);
      w += funct_tab[r.op];
    end else begin
      w = opcode_tab[r.op - 6] * (1 << 26) + int'(r.rs) * (1 << 21)
        + int'(r.rt) * (1 << 16) + int'(r.imm);
    end
    return 32'(w);
  endfunction

  function automatic req_t rand_req(input logic legal_only);
    req_t r;
    r.op  = legal_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
    r.rs  = 5'($urandom);
    r.rt  = 5'($urandom);
    r.rd  = 5'($urandom);
    r.sh  = 5'($urandom);
    r.imm = 16'($urandom);
    return r;
  endfunction

  task automatic drive(input logic v, input req_t r);
    in_valid = v;
    in_op    = r.op;
    in_rs    = r.rs;
    in_rt    = r.rt;
    in_rd    = r.rd;
    in_shamt = r.sh;
    in_imm   = r.imm;
  endtask

  function automatic req_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
    req_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh; r.imm = imm;
    return r;
  endfunction

  // Compare outputs against the model, then advance model and DUT by one clock.
  task automatic step();
    req_t  cur;
    logic  acc, pop;
    logic [31:0] head;
    head = (mq.size() != 0) ? mq[0] : 32'h0;
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 4));
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_eq("out_instr", out_instr, head);
    check_eq("err", 32'(err), 32'(err_exp));
`ifdef ENC_PARITY_EN
    check_eq("out_parity", 32'(out_parity), 32'(^head));
`endif
    cur = mk(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm);
    acc = in_valid && (mq.size() < 4);
    pop = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc && is_legal(cur.op)) mq.push_back(ref_enc(cur));
    err_exp = acc && !is_legal(cur.op);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lit[4];
    req_t r;
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    err_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 1);

    // Single ADD, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, mk(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0));
    step();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    check_eq("add_word", out_instr, 32'h00221820);
`ifdef ENC_PARITY_EN
    check_eq("add_parity", 32'(out_parity), 1);
`endif
    step();

    // Four ops back to back
    lit = '{32'h8FA80004, 32'h1020FFFF, 32'h00095100, 32'h20050010};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: r = mk(4'd6, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004);
        1: r = mk(4'd8, 5'd1, 5'd0, 5'd0, 5'd0, 16'hFFFF);
        2: r = mk(4'd5, 5'd7, 5'd9, 5'd10, 5'd4, 16'h0);
        default: r = mk(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010);
      endcase
      drive(1'b1, r);
      step();
      check_eq($sformatf("b2b_word%0d", i), out_instr, lit[i]);
    end
    drive(1'b0, r);
    step();

    // Fill to full with out_ready low; fifth request held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) held[i] = rand_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, held[i]);
      step();
    end
    drive(1'b1, held[4]);
    step();
    step();
    check_eq("full_count", 32'(count), 4);
    check_eq("full_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("pop_one_count", 32'(count), 3);
    step();
    drive(1'b0, held[4]);
    check_eq("refill_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("drain%0d", i), out_instr, ref_enc(held[i]));
      step();
    end

    // Illegal ops, single then back to back
    drive(1'b1, mk(4'hF, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234));
    step();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    check_eq("illegal_err", 32'(err), 1);
    check_eq("illegal_count", 32'(count), 0);
    step();
    check_eq("illegal_err_clear", 32'(err), 0);
    drive(1'b1, mk(4'd10, 0, 0, 0, 0, 0));
    step();
    drive(1'b1, mk(4'd13, 0, 0, 0, 0, 0));
    step();
    drive(1'b0, mk(0, 0, 0, 0, 0, 0));
    check_eq("illegal_b2b_err", 32'(err), 1);
    step();

    // Hold at count=2 with simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, rand_req(1'b1));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_req(1'b1));
      step();
      check_eq("pushpop_count", 32'(count), 2);
    end
    drive(1'b0, rand_req(1'b1));
    step();
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_req(1'($urandom_range(0, 4) != 0)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, rand_req(1'b1));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Asynchronous reset with words queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_req(1'b1));
      step();
    end
    drive(1'b0, rand_req(1'b1));
    check_eq("pre_reset_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 0);
    check_eq("async_rst_count", 32'(count), 0);
    check_eq("async_rst_out_instr", out_instr, 0);
    mq.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_reset_in_ready", 32'(in_ready), 1);
    drive(1'b1, mk(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0));
    step();
    drive(1'b0, rand_req(1'b1));
    check_eq("post_reset_count", 32'(count), 1);
    check_eq("post_reset_word", out_instr, 32'h00221820);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
